// File: rtl/data_read_unit_pkg.sv
// Shared constants and read-state encoding for the ONFI data-read engine.
// The RE# pulse widths here are the default phase lengths of data_read_unit.
package data_read_unit_pkg;

    localparam int T_RP_CYCLES  = 4;
    localparam int T_REH_CYCLES = 2;
    localparam int INIT_CYCLES  = 16;
    localparam int TIMER_W      = 8;
    localparam int WORD_W       = 16;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_RE_LOW  = 3'd2,
        ST_RE_HIGH = 3'd3,
        ST_DONE    = 3'd4
    } read_state_t;

    // The phase timer expires on its final cycle, so an N-cycle phase loads N-1.
    function automatic logic [TIMER_W-1:0] phase_load(input int cycles);
        return TIMER_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/data_read_unit_phase_timer.sv
// onfi_phase_timer: loadable down-counter that asserts expire on the last cycle
// of a phase. Reset preloads it so the INIT phase starts counting immediately.
module onfi_phase_timer
    import data_read_unit_pkg::*;
#(
    parameter logic [TIMER_W-1:0] RESET_LOAD = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] value,
    output logic               expire
);

    logic [TIMER_W-1:0] remaining;

    always_ff @(posedge clk) begin
        if (reset) begin
            remaining <= RESET_LOAD;
        end else if (load) begin
            remaining <= value;
        end else if (remaining != '0) begin
            remaining <= remaining - TIMER_W'(1);
        end
    end

    assign expire = (remaining == '0);

endmodule

// File: rtl/data_read_unit.sv
// data_read_unit: strobes RE# to pull a burst of words off the NAND DQ bus.
// Optional feature macro: DATA_READ_CHECKSUM_EN enables the 16-bit burst word sum.
module data_read_unit
    import data_read_unit_pkg::*;
#(
    parameter int T_RP  = T_RP_CYCLES,
    parameter int T_REH = T_REH_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              activate,
    input  logic [WORD_W-1:0] count,
    input  logic [WORD_W-1:0] data_in,
    output logic              read_enable,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic              done,
    output logic              busy,
    output logic              initialized,
    output logic [WORD_W-1:0] checksum,
    output read_state_t       state
);

    // Handshake: activate is a level request taken only on an IDLE edge with
    // count != 0 (no queueing while busy); data_valid is a one-cycle strobe
    // with no back-pressure, so the core must take data_out in that cycle.

    read_state_t        state_next;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_expire;
    logic               accept;
    logic               capture;
    logic [WORD_W-1:0]  remaining;

    onfi_phase_timer #(
        .RESET_LOAD (phase_load(INIT_CYCLES))
    ) u_phase_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .value  (timer_value),
        .expire (timer_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        timer_load  = 1'b0;
        timer_value = '0;
        accept      = 1'b0;
        capture     = 1'b0;
        case (state)
            ST_INIT: begin
                if (timer_expire) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (activate && (count != '0)) begin
                    accept      = 1'b1;
                    timer_load  = 1'b1;
                    timer_value = phase_load(T_RP);
                    state_next  = ST_RE_LOW;
                end
            end
            ST_RE_LOW: begin
                if (timer_expire) begin
                    capture     = 1'b1;
                    timer_load  = 1'b1;
                    timer_value = phase_load(T_REH);
                    state_next  = ST_RE_HIGH;
                end
            end
            ST_RE_HIGH: begin
                if (timer_expire) begin
                    if (remaining != '0) begin
                        timer_load  = 1'b1;
                        timer_value = phase_load(T_RP);
                        state_next  = ST_RE_LOW;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            initialized <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            remaining   <= '0;
        end else begin
            data_valid <= capture;
            if ((state == ST_INIT) && timer_expire) begin
                initialized <= 1'b1;
            end
            if (accept) begin
                remaining <= count;
            end else if (capture) begin
                data_out <= data_in;
                // Saturate so a stray capture can never wrap the word count.
                if (remaining != '0) begin
                    remaining <= remaining - WORD_W'(1);
                end
            end
        end
    end

`ifdef DATA_READ_CHECKSUM_EN
    logic [WORD_W-1:0] word_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            word_sum <= '0;
        end else if (accept) begin
            word_sum <= '0;
        end else if (capture) begin
            word_sum <= word_sum + data_in;
        end
    end

    assign checksum = word_sum;
`else
    assign checksum = '0;
`endif

    assign read_enable = (state != ST_RE_LOW);
    assign done        = (state == ST_DONE);
    assign busy        = (state != ST_IDLE) || !initialized;

endmodule

// File: tb/tb_data_read_unit.sv
// Directed bench for data_read_unit: INIT, single and multi-word bursts,
// zero-count requests, mid-burst reset and back-to-back activation.
module tb_data_read_unit;
    import data_read_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        activate;
    logic [15:0] count;
    logic [15:0] data_in;
    logic        read_enable;
    logic [15:0] data_out;
    logic        data_valid;
    logic        done;
    logic        busy;
    logic        initialized;
    logic [15:0] checksum;
    read_state_t state;

    int errors = 0;
    int checks = 0;

    data_read_unit dut (
        .clk         (clk),
        .reset       (reset),
        .activate    (activate),
        .count       (count),
        .data_in     (data_in),
        .read_enable (read_enable),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .done        (done),
        .busy        (busy),
        .initialized (initialized),
        .checksum    (checksum),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Leaves the caller at the sample point of the first cycle after the accept edge.
    task automatic start_burst(input logic [15:0] n, input logic hold);
        activate = 1'b1;
        count    = n;
        @(posedge clk);
        @(negedge clk);
        activate = hold;
    endtask

    task automatic test_reset();
        activate = 1'b1;
        count    = 16'd5;
        data_in  = 16'h0000;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 17) activate = 1'b0;
            checks++;
            if (initialized !== (c == 17)) begin
                errors++;
                $display("FAIL reset_initialized cycle %0d: got %b want %b", c, initialized, (c == 17));
            end
            checks++;
            if (busy !== (c < 17)) begin
                errors++;
                $display("FAIL reset_busy cycle %0d: got %b want %b", c, busy, (c < 17));
            end
            checks++;
            if (read_enable !== 1'b1) begin
                errors++;
                $display("FAIL reset_re cycle %0d: got %b want 1", c, read_enable);
            end
            if (c == 1) begin
                checks++;
                if (data_out !== 16'h0 || data_valid !== 1'b0 || done !== 1'b0 || checksum !== 16'h0) begin
                    errors++;
                    $display("FAIL reset_outputs: data_out=%h valid=%b done=%b checksum=%h want 0", data_out, data_valid, done, checksum);
                end
            end
        end
        checks++;
        if (state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d want %0d", state, ST_IDLE);
        end
    endtask

    task automatic test_single();
        data_in = 16'hA5C3;
        start_burst(16'd1, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            checks++;
            if (read_enable !== !(c <= 4)) begin
                errors++;
                $display("FAIL single_re cycle %0d: got %b want %b", c, read_enable, !(c <= 4));
            end
            checks++;
            if (data_valid !== (c == 5)) begin
                errors++;
                $display("FAIL single_valid cycle %0d: got %b want %b", c, data_valid, (c == 5));
            end
            checks++;
            if (done !== (c == 7)) begin
                errors++;
                $display("FAIL single_done cycle %0d: got %b want %b", c, done, (c == 7));
            end
            checks++;
            if (busy !== (c < 8)) begin
                errors++;
                $display("FAIL single_busy cycle %0d: got %b want %b", c, busy, (c < 8));
            end
            if (c >= 5) begin
                checks++;
                if (data_out !== 16'hA5C3) begin
                    errors++;
                    $display("FAIL single_data cycle %0d: got %h want a5c3", c, data_out);
                end
            end
            if (c == 7) begin
                checks++;
`ifdef DATA_READ_CHECKSUM_EN
                if (checksum !== 16'hA5C3) begin
`else
                if (checksum !== 16'h0000) begin
`endif
                    errors++;
                    $display("FAIL single_checksum: got %h", checksum);
                end
            end
        end
    endtask

    task automatic test_burst3();
        logic [15:0] words [3];
        logic [15:0] exp_word;
        words[0] = 16'h0001;
        words[1] = 16'h0002;
        words[2] = 16'hFFFF;
        data_in  = 16'h5555;
        start_burst(16'd3, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            if (c <= 18) data_in = words[(c - 1) / 6];
            checks++;
            if (data_valid !== (c == 5 || c == 11 || c == 17)) begin
                errors++;
                $display("FAIL burst3_valid cycle %0d: got %b", c, data_valid);
            end
            if (c == 5 || c == 11 || c == 17) begin
                exp_word = words[(c - 1) / 6];
                checks++;
                if (data_out !== exp_word) begin
                    errors++;
                    $display("FAIL burst3_data cycle %0d: got %h want %h", c, data_out, exp_word);
                end
            end
            checks++;
            if (done !== (c == 19)) begin
                errors++;
                $display("FAIL burst3_done cycle %0d: got %b want %b", c, done, (c == 19));
            end
            if (c == 19) begin
                checks++;
`ifdef DATA_READ_CHECKSUM_EN
                if (checksum !== 16'h0002) begin
`else
                if (checksum !== 16'h0000) begin
`endif
                    errors++;
                    $display("FAIL burst3_checksum: got %h", checksum);
                end
            end
            if (c == 20) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL burst3_busy_fall: got %b want 0", busy);
                end
            end
        end
    endtask

    task automatic test_zero_count();
        activate = 1'b1;
        count    = 16'd0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (read_enable !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL zero_count cycle %0d: re=%b done=%b busy=%b want 1/0/0", c, read_enable, done, busy);
            end
        end
        activate = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        data_in = 16'h0F0F;
        start_burst(16'd4, 1'b0);
        for (int c = 1; c <= 25; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 8) begin
                checks++;
                if (read_enable !== 1'b0) begin
                    errors++;
                    $display("FAIL midreset_re_before: got %b want 0", read_enable);
                end
                reset = 1'b1;
            end else if (c == 9) begin
                reset = 1'b0;
                checks++;
                if (read_enable !== 1'b1 || data_valid !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL midreset_outputs: re=%b valid=%b busy=%b want 1/0/1", read_enable, data_valid, busy);
                end
                checks++;
                if (data_out !== 16'h0 || checksum !== 16'h0 || initialized !== 1'b0) begin
                    errors++;
                    $display("FAIL midreset_regs: data_out=%h checksum=%h init=%b want 0", data_out, checksum, initialized);
                end
            end
            if (c >= 9) begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL midreset_done cycle %0d: got %b want 0", c, done);
                end
                checks++;
                if (initialized !== (c == 25)) begin
                    errors++;
                    $display("FAIL midreset_init cycle %0d: got %b want %b", c, initialized, (c == 25));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int done_seen;
        bit finished;
        data_in = 16'h1234;
        start_burst(16'd2, 1'b1);
        for (int c = 1; c <= 15; c++) begin
            if (c > 1) @(negedge clk);
            if (c <= 13) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_busy cycle %0d: got %b want 1", c, busy);
                end
            end
            if (c == 13) begin
                checks++;
                if (done !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_done: got %b want 1", done);
                end
                checks++;
`ifdef DATA_READ_CHECKSUM_EN
                if (checksum !== 16'h2468) begin
`else
                if (checksum !== 16'h0000) begin
`endif
                    errors++;
                    $display("FAIL b2b_checksum: got %h", checksum);
                end
            end
            if (c == 14) begin
                checks++;
                if (busy !== 1'b0 || read_enable !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_gap: busy=%b re=%b done=%b want 0/1/0", busy, read_enable, done);
                end
            end
            if (c == 15) begin
                activate = 1'b0;
                checks++;
                if (read_enable !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_restart: re=%b busy=%b want 0/1", read_enable, busy);
                end
            end
        end
        done_seen = 0;
        finished  = 1'b0;
        for (int c = 16; c <= 60 && !finished; c++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
            if (busy === 1'b0) begin
                finished = 1'b1;
                checks++;
                if (c != 28) begin
                    errors++;
                    $display("FAIL b2b_second_end: busy fell in cycle %0d want 28", c);
                end
            end
        end
        checks++;
        if (!finished || done_seen != 1) begin
            errors++;
            $display("FAIL b2b_second_burst: finished=%b done pulses=%0d want 1/1", finished, done_seen);
        end
    endtask

    initial begin
        reset    = 1'b1;
        activate = 1'b0;
        count    = 16'd0;
        data_in  = 16'd0;
        @(negedge clk);
        test_reset();
        test_single();
        test_burst3();
        test_zero_count();
        test_reset_mid_burst();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
